wrap_word_combine_pipe: RTL and testbench
=========================================

Name: wrap_word_combine_pipe

Overview:
Streams wrap-boundary word fix-ups for the sparse polynomial multiplier. Each request carries the three source words around the x^N wrap point (word 0, second-to-last word, partial last word), a shift and an accumulator word. The block forms the rotated boundary word and XORs it into the accumulator word. It is a parametrised, pipelined, back-pressured successor of the single-shot initial shift processor: generic word width and tail size, a queued input, and a tagged output.

Parameters:
WORD_WIDTH, 32, datapath word width W
TAIL_BITS, 5, valid bits T in the last polynomial word; 1 <= T < W
SHIFT_W, 16, shift field width
IDX_W, 6, shift-index width; must hold values 0..W
TAG_W, 4, request tag width, passed through unchanged
DEPTH, 4, input FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  FIFO not full
in_tag  in  TAG_W  request tag
in_shift  in  SHIFT_W  shift; t = in_shift mod W
in_shift_idx  in  IDX_W  high-bit count k taken from word 0
in_word_zero  in  W  polynomial word 0
in_word_lm1  in  W  second-to-last word
in_word_last  in  W  last word; only [T-1:0] used
in_acc_word  in  W  accumulator word
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_tag  out  TAG_W  tag of result
out_result  out  W  acc XOR combined
busy  out  1  any FIFO entry or pipe stage occupied

Behaviour:
- Reset: clk is the single clock. rst_n is asynchronous and active-low. Reset clears FIFO pointers and count, both stage valids, out_valid, out_result, out_tag and busy to 0. After reset, in_ready=1. Reset asserted mid-operation discards all queued and in-flight requests; no partial output is produced.
- Transfers: an input transfer occurs when in_valid&&in_ready at a rising edge; the whole request is written to the FIFO. An output transfer occurs when out_valid&&out_ready.
- in_ready: in_ready = (count != DEPTH), derived from registered state only. When full, in_ready=0 even if a pop happens in the same cycle. Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Stage 1 (EXTRACT): loads the FIFO head when the FIFO is non-empty and stage 1 is empty or advancing. It registers the combined word C, the acc word and the tag. Z = word_zero masked to its low k bits.
  - Mode A, t >= T: C = bits [k+T+W-1 : k+T] of the concatenation {Z, word_last[T-1:0], word_lm1}. Requires k <= W-T. If k > W-T, C is taken as 0, with no X propagation.
  - Mode B, t < T: C = (Z << t) | word_last[T-1 : T-t]. For t=0, C = Z.
  - All shifts are computed at full 2W+T width, so there is no 32-bit overflow for any k in 0..W. k=0 gives Z=0. k>=W gives Z=word_zero.
- Stage 2 (OUTPUT): out_result <= acc XOR C and out_tag <= tag, with out_valid set. Stage 2 loads when stage 1 is valid and (!out_valid || out_ready). Otherwise it holds all outputs stable while out_valid&&!out_ready.
- Stage 1 advances iff stage 2 loads. Stage 1 holds under a stall.
- Latency: a request accepted at edge E0 into an empty pipe with out_ready=1 enters stage 1 at E1. out_valid is seen high after E2.
- Throughput: one result per cycle when sustained. Order is strictly FIFO; tags come out in acceptance order.
- Zero-bubble stall: with out_ready low, up to DEPTH+2 requests are held with no loss. out_valid clears only after an output transfer with no new stage-2 load.
- busy = (count!=0) | s1_valid | out_valid.

Optional Feature:
- Macro: WRAP_COMBINE_CNT_EN.
- Defined: adds output port done_cnt [15:0]. It resets to 0 and increments by 1 on each output transfer, wrapping 0xFFFF->0. It also adds output mode_a_cnt [15:0], which counts output transfers whose request was Mode A, with the same wrap behaviour.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Mode A (W=32,T=5): shift=37, k=3, zero=0x5, last=0x0A, lm1=0x80000000, acc=0x0000FFFF, tag=2, out_ready=1 -> out_result=0xAA80FFFF, out_tag=2, out_valid rises 2 cycles after the accept edge.
- Mode B: shift=2, k=30, zero=0xFFFFFFFF, last=0x10, acc=0x1 -> out_result=0xFFFFFFFF. Mode B with shift=0, k=0, acc=0x1234 -> 0x1234.
- Backpressure: out_ready=0, push 6 requests with tags 0..5 (DEPTH=4) -> in_ready falls after the 6th accept. Release out_ready -> 6 results, tags 0..5 in order, one per cycle, no loss or duplication.
- Reset mid-flight: 3 requests queued, rst_n pulsed low between edges -> out_valid, busy and count drop to 0 immediately, in_ready=1, and no stale result follows.
- Boundary k: Mode A with k=28 (>W-T) -> out_result=acc. k=32 in Mode B uses the full word_zero.
- WRAP_COMBINE_CNT_EN: 3 Mode A + 2 Mode B transfers -> done_cnt=5, mode_a_cnt=3. Preload near the limit by driving 65537 transfers -> done_cnt=1.

Source files
------------

// File: rtl/wrap_word_combine_pipe.sv
// Pipelined wrap-boundary word combiner: input FIFO, extract stage, registered output stage.
// Define WRAP_COMBINE_CNT_EN to add the done_cnt / mode_a_cnt transfer counters.
module wrap_word_combine_pipe #(
    parameter int WORD_WIDTH = 32,
    parameter int TAIL_BITS  = 5,
    parameter int SHIFT_W    = 16,
    parameter int IDX_W      = 6,
    parameter int TAG_W      = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [SHIFT_W-1:0]    in_shift,
    input  logic [IDX_W-1:0]      in_shift_idx,
    input  logic [WORD_WIDTH-1:0] in_word_zero,
    input  logic [WORD_WIDTH-1:0] in_word_lm1,
    input  logic [WORD_WIDTH-1:0] in_word_last,
    input  logic [WORD_WIDTH-1:0] in_acc_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_W-1:0]      out_tag,
    output logic [WORD_WIDTH-1:0] out_result,
    output logic                  busy
`ifdef WRAP_COMBINE_CNT_EN
   ,output logic [15:0]           done_cnt,
    output logic [15:0]           mode_a_cnt
`endif
);
    localparam int W  = WORD_WIDTH;
    localparam int T  = TAIL_BITS;
    localparam int XW = 2 * W + T;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [IDX_W-1:0] K_MAX = IDX_W'(W - T);

    logic [TAG_W-1:0]   fifo_tag  [DEPTH];
    logic [SHIFT_W-1:0] fifo_shift[DEPTH];
    logic [IDX_W-1:0]   fifo_idx  [DEPTH];
    logic [W-1:0]       fifo_zero [DEPTH];
    logic [W-1:0]       fifo_lm1  [DEPTH];
    logic [T-1:0]       fifo_last [DEPTH];
    logic [W-1:0]       fifo_acc  [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_c_q, s1_c_d, s1_acc_q, s1_acc_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
`ifdef WRAP_COMBINE_CNT_EN
    logic             s1_mode_a_q, s1_mode_a_d, s2_mode_a_q, s2_mode_a_d;
    logic [15:0]      done_cnt_q, done_cnt_d, mode_a_cnt_q, mode_a_cnt_d;
`endif

    logic             push, s1_load, s2_load, head_mode_a;
    logic [SHIFT_W-1:0] head_t;
    logic [IDX_W-1:0] head_k;
    logic [W-1:0]     head_z, head_c;

    // Head extraction; all shifts evaluated at 2W+T bits so k up to W never overflows.
    always_comb begin
        head_t      = fifo_shift[rd_ptr_q] % SHIFT_W'(W);
        head_k      = fifo_idx[rd_ptr_q];
        head_z      = fifo_zero[rd_ptr_q] & ~({W{1'b1}} << head_k);
        head_mode_a = head_t >= SHIFT_W'(T);
        if (head_mode_a) begin
            head_c = (head_k > K_MAX) ? '0 :
                     W'({head_z, fifo_last[rd_ptr_q], fifo_lm1[rd_ptr_q]} >> (32'(head_k) + T));
        end else begin
            head_c = W'((XW'(head_z) << head_t) |
                        (XW'(fifo_last[rd_ptr_q]) >> (SHIFT_W'(T) - head_t)));
        end
    end

    always_comb begin
        in_ready = (count_q != CW'(DEPTH));
        push     = in_valid && in_ready;
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        s1_load  = (count_q != '0) && (!s1_valid_q || s2_load);

        wr_ptr_d     = push    ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = s1_load ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(s1_load);

        s1_valid_d   = s1_valid_q;
        s1_c_d       = s1_c_q;
        s1_acc_d     = s1_acc_q;
        s1_tag_d     = s1_tag_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
`ifdef WRAP_COMBINE_CNT_EN
        s1_mode_a_d  = s1_mode_a_q;
        s2_mode_a_d  = s2_mode_a_q;
        done_cnt_d   = done_cnt_q;
        mode_a_cnt_d = mode_a_cnt_q;
        if (out_valid_q && out_ready) begin
            done_cnt_d   = done_cnt_q + 16'd1;
            mode_a_cnt_d = mode_a_cnt_q + 16'(s2_mode_a_q);
        end
`endif

        if (s1_load) begin
            s1_valid_d  = 1'b1;
            s1_c_d      = head_c;
            s1_acc_d    = fifo_acc[rd_ptr_q];
            s1_tag_d    = fifo_tag[rd_ptr_q];
`ifdef WRAP_COMBINE_CNT_EN
            s1_mode_a_d = head_mode_a;
`endif
        end else if (s2_load) begin
            s1_valid_d  = 1'b0;
        end

        if (s2_load) begin
            out_valid_d  = 1'b1;
            out_result_d = s1_acc_q ^ s1_c_q;
            out_tag_d    = s1_tag_q;
`ifdef WRAP_COMBINE_CNT_EN
            s2_mode_a_d  = s1_mode_a_q;
`endif
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_tag[wr_ptr_q]   <= in_tag;
            fifo_shift[wr_ptr_q] <= in_shift;
            fifo_idx[wr_ptr_q]   <= in_shift_idx;
            fifo_zero[wr_ptr_q]  <= in_word_zero;
            fifo_lm1[wr_ptr_q]   <= in_word_lm1;
            fifo_last[wr_ptr_q]  <= in_word_last[T-1:0];
            fifo_acc[wr_ptr_q]   <= in_acc_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_c_q       <= '0;
            s1_acc_q     <= '0;
            s1_tag_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
`ifdef WRAP_COMBINE_CNT_EN
            s1_mode_a_q  <= 1'b0;
            s2_mode_a_q  <= 1'b0;
            done_cnt_q   <= '0;
            mode_a_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            s1_valid_q   <= s1_valid_d;
            s1_c_q       <= s1_c_d;
            s1_acc_q     <= s1_acc_d;
            s1_tag_q     <= s1_tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
`ifdef WRAP_COMBINE_CNT_EN
            s1_mode_a_q  <= s1_mode_a_d;
            s2_mode_a_q  <= s2_mode_a_d;
            done_cnt_q   <= done_cnt_d;
            mode_a_cnt_q <= mode_a_cnt_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign busy       = (count_q != '0) | s1_valid_q | out_valid_q;
`ifdef WRAP_COMBINE_CNT_EN
    assign done_cnt   = done_cnt_q;
    assign mode_a_cnt = mode_a_cnt_q;
`endif

endmodule

// File: tb/tb_wrap_word_combine_pipe.sv
// Directed + scoreboard bench for wrap_word_combine_pipe (W=32, T=5, DEPTH=4).
module tb_wrap_word_combine_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_tag;
    logic [15:0] in_shift;
    logic [5:0]  in_shift_idx;
    logic [31:0] in_word_zero, in_word_lm1, in_word_last, in_acc_word;
    logic        out_valid, out_ready;
    logic [3:0]  out_tag;
    logic [31:0] out_result;
    logic        busy;
`ifdef WRAP_COMBINE_CNT_EN
    logic [15:0] done_cnt, mode_a_cnt;
`endif

    wrap_word_combine_pipe #(
        .WORD_WIDTH(32), .TAIL_BITS(5), .SHIFT_W(16),
        .IDX_W(6), .TAG_W(4), .DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_shift(in_shift), .in_shift_idx(in_shift_idx),
        .in_word_zero(in_word_zero), .in_word_lm1(in_word_lm1),
        .in_word_last(in_word_last), .in_acc_word(in_acc_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_result(out_result), .busy(busy)
`ifdef WRAP_COMBINE_CNT_EN
       ,.done_cnt(done_cnt), .mode_a_cnt(mode_a_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] res;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    endtask

    // Bit-by-bit reference of the boundary word, independent of shift operators.
    function automatic logic [31:0] model_c(input logic [15:0] shift, input logic [5:0] k,
                                            input logic [31:0] zero, input logic [31:0] lm1,
                                            input logic [31:0] last);
        int t;
        int j;
        logic [31:0] z;
        logic [31:0] c;
        t = int'(shift) % 32;
        for (int i = 0; i < 32; i++) z[i] = (i < int'(k)) ? zero[i] : 1'b0;
        c = '0;
        if (t >= 5) begin
            if (int'(k) <= 27) begin
                for (int i = 0; i < 32; i++) begin
                    j = i + int'(k) + 5;
                    if (j < 32)      c[i] = lm1[j];
                    else if (j < 37) c[i] = last[j-32];
                    else             c[i] = z[j-37];
                end
            end
        end else begin
            for (int i = 0; i < 32; i++) c[i] = (i >= t) ? z[i-t] : last[5-t+i];
        end
        return c;
    endfunction

    task automatic send(input logic [3:0] tag, input logic [15:0] shift, input logic [5:0] k,
                        input logic [31:0] zero, input logic [31:0] lm1,
                        input logic [31:0] last, input logic [31:0] acc);
        int n;
        exp_t e;
        in_tag = tag; in_shift = shift; in_shift_idx = k;
        in_word_zero = zero; in_word_lm1 = lm1; in_word_last = last; in_acc_word = acc;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        e.tag = tag;
        e.res = acc ^ model_c(shift, k, zero, lm1, last);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("extra_output", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_tag", 32'(out_tag), 32'(e.tag));
                check("sb_result", out_result, e.res);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_tag = '0; in_shift = '0; in_shift_idx = '0;
        in_word_zero = '0; in_word_lm1 = '0; in_word_last = '0; in_acc_word = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode A directed, with latency
        send(4'd2, 16'd37, 6'd3, 32'h5, 32'h80000000, 32'h0A, 32'h0000FFFF);
        check("lat_e0", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e2", 32'(out_valid), 32'd1);
        check("modeA_result", out_result, 32'hAA80FFFF);
        check("modeA_tag", 32'(out_tag), 32'd2);
        @(negedge clk);

        send(4'd3, 16'd2, 6'd30, 32'hFFFFFFFF, 32'h0, 32'h10, 32'h1);
        @(posedge clk); @(posedge clk); #1;
        check("modeB_result", out_result, 32'hFFFFFFFF);
        @(negedge clk);

        send(4'd4, 16'd0, 6'd0, 32'hDEADBEEF, 32'h12345678, 32'h1F, 32'h1234);
        @(posedge clk); @(posedge clk); #1;
        check("modeB_t0_result", out_result, 32'h1234);
        @(negedge clk);

        send(4'd5, 16'd40, 6'd28, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1F, 32'hCAFE0001);
        @(posedge clk); @(posedge clk); #1;
        check("modeA_k28_result", out_result, 32'hCAFE0001);
        @(negedge clk);

        send(4'd6, 16'd1, 6'd32, 32'h80000001, 32'h0, 32'h1F, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        check("modeB_k32_result", out_result, 32'h3);
        @(negedge clk);
        drain();

        // Backpressure: DEPTH + 2 requests held
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("rdy_before_6th", 32'(in_ready), 32'd1);
            send(4'(i), 16'($urandom), 6'($urandom_range(0, 32)), $urandom, $urandom, $urandom, $urandom);
        end
        check("rdy_full", 32'(in_ready), 32'd0);
        check("busy_full", 32'(busy), 32'd1);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_tag", 32'(out_tag), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("thru_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        check("thru_end", 32'(out_valid), 32'd0);
        drain();

        // Random traffic with gaps
        for (int i = 0; i < 16; i++) begin
            send(4'(i), 16'($urandom), 6'($urandom_range(0, 32)), $urandom, $urandom, $urandom, $urandom);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        drain();

        // Reset mid-flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'(i + 8), 16'd37, 6'd3, $urandom, $urandom, $urandom, $urandom);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale", 32'(out_valid), 32'd0);
        end

`ifdef WRAP_COMBINE_CNT_EN
        for (int i = 0; i < 3; i++) send(4'(i), 16'd37, 6'd3, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 2; i++) send(4'(i + 3), 16'd2, 6'd30, $urandom, $urandom, $urandom, $urandom);
        drain();
        check("done_cnt_5", 32'(done_cnt), 32'd5);
        check("mode_a_cnt_3", 32'(mode_a_cnt), 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) send(4'(i), 16'd0, 6'd4, 32'hF, 32'h0, 32'h0, 32'h0);
        drain();
        check("done_cnt_wrap", 32'(done_cnt), 32'd1);
        check("mode_a_cnt_wrap", 32'(mode_a_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
